updown_counter_param: RTL and testbench
=======================================

UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the counter width in bits.
REQ-002 Parameter MAX_VAL SHALL default to 2**WIDTH-1 and set the terminal count; legal range is 1..2**WIDTH-1.
REQ-003 Parameter STEP_W SHALL default to 4 and set the width of the step input; constraint is 2**STEP_W-1 <= MAX_VAL, otherwise elaboration fails.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 enable  input  1  SHALL permit counting when 1 and hold the count when 0.
REQ-007 direction  input  1  SHALL select the count direction: 1 = up, 0 = down.
REQ-008 step  input  STEP_W  SHALL be the unsigned increment/decrement per enabled cycle; 0 holds the count.
REQ-009 load  input  1  SHALL synchronously load load_value when 1.
REQ-010 load_value  input  WIDTH  SHALL be the value to load.
REQ-011 clr_flag  input  1  SHALL synchronously clear the sticky overflow flag.
REQ-012 counter_out  output  WIDTH  SHALL be the registered count.
REQ-013 wrap  output  1  SHALL be a registered one-cycle pulse marking a boundary event.
REQ-014 ovf_sticky  output  1  SHALL be a registered flag, set by any wrap pulse and held until cleared.
REQ-015 at_max / at_zero  output  1 each  SHALL be combinational decodes: counter_out==MAX_VAL and counter_out==0.

Function
REQ-016 Per-edge priority SHALL be: load > (enable==0 or step==0: hold) > count.
REQ-017 On load, counter_out SHALL take min(load_value, MAX_VAL) on the next edge; wrap SHALL be 0 in that cycle.
REQ-018 Up count SHALL give c+step when c+step <= MAX_VAL, else c+step-(MAX_VAL+1), with wrap=1.
REQ-019 Down count SHALL give c-step when step <= c, else c-step+(MAX_VAL+1), with wrap=1.
REQ-020 Arithmetic SHALL use WIDTH+1 bits internally so no intermediate value truncates; counter_out SHALL never exceed MAX_VAL.
REQ-021 wrap SHALL be 0 in every cycle without a boundary event; counter latency SHALL be one cycle from input to counter_out.
REQ-022 ovf_sticky SHALL set in the same edge that raises wrap; if clr_flag and a wrap event coincide, set SHALL win.
REQ-023 direction, step and enable SHALL be sampled every edge; changing them mid-count SHALL take effect immediately.

Reset
REQ-024 While rst_n==0, counter_out SHALL be 0, wrap 0 and ovf_sticky 0, without waiting for clk.
REQ-025 Reset asserted mid-count SHALL discard the in-flight update; the first edge after rst_n rises SHALL act normally.

Configuration
REQ-026 With macro UPDOWN_COUNTER_SAT_EN defined, REQ-018/019 crossings SHALL saturate at MAX_VAL (up) or 0 (down) instead of wrapping.
REQ-027 In saturate mode, wrap SHALL pulse on any attempted crossing, including while already held at the limit, and ovf_sticky SHALL set.
REQ-028 Without UPDOWN_COUNTER_SAT_EN, the block SHALL wrap modulo MAX_VAL+1 and contain no saturation logic.

Verification (WIDTH=8, MAX_VAL=9, STEP_W=3)
REQ-029 Reset release, enable=1, dir=1, step=1, 12 edges -> 1..9,0,1,2; wrap high only on the 9->0 edge.
REQ-030 Load 7, dir=0, step=3 -> 4,1,8 (wrap), 5; ovf_sticky=1 from the 1->8 edge.
REQ-031 Load 200 -> counter_out=9, at_max=1, wrap=0; load together with enable=1 -> load wins.
REQ-032 enable=0 or step=0 for 5 edges -> value unchanged, wrap=0; clr_flag coincident with wrap -> ovf_sticky stays 1; clr_flag alone -> 0.
REQ-033 rst_n pulsed low between edges mid-count -> outputs 0 immediately; next edge counts from 0.
REQ-034 SAT_EN build: at 8, up step=3 -> 9 with wrap=1; next edge stays 9 with wrap=1; down from 1, step=2 -> 0.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with step, load, wrap pulse and sticky overflow flag.
// Define UPDOWN_COUNTER_SAT_EN to clamp at 0 / MAX_VAL instead of wrapping.
module updown_counter_param #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              direction,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              clr_flag,
  output logic [WIDTH-1:0]  counter_out,
  output logic              wrap,
  output logic              ovf_sticky,
  output logic              at_max,
  output logic              at_zero
);

  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL out of range 1..2**WIDTH-1");
  end
  if ((2**STEP_W)-1 > MAX_VAL) begin : g_bad_step
    $error("updown_counter_param: 2**STEP_W-1 must not exceed MAX_VAL");
  end

  // One extra bit so c+step and c+MOD never truncate.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + (WIDTH+1)'(1);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum_up;

  assign cnt_ext  = {1'b0, counter_q};
  assign step_ext = (WIDTH+1)'(step);
  assign sum_up   = cnt_ext + step_ext;

  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
    if (load) begin
      counter_d = ({1'b0, load_value} > MAX_EXT) ? WIDTH'(MAX_EXT) : load_value;
    end else if (enable && (step != '0)) begin
      if (direction) begin
        if (sum_up > MAX_EXT) begin
          wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SAT_EN
          counter_d = WIDTH'(MAX_EXT);
`else
          counter_d = WIDTH'(sum_up - MOD_EXT);
`endif
        end else begin
          counter_d = WIDTH'(sum_up);
        end
      end else begin
        if (step_ext > cnt_ext) begin
          wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SAT_EN
          counter_d = '0;
`else
          counter_d = WIDTH'(cnt_ext + MOD_EXT - step_ext);
`endif
        end else begin
          counter_d = WIDTH'(cnt_ext - step_ext);
        end
      end
    end
  end

  // A boundary event in the same cycle as clr_flag keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (wrap_d)        ovf_d = 1'b1;
    else if (clr_flag) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      wrap_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
      ovf_q     <= ovf_d;
    end
  end

  assign counter_out = counter_q;
  assign wrap        = wrap_q;
  assign ovf_sticky  = ovf_q;
  assign at_max      = (cnt_ext == MAX_EXT);
  assign at_zero     = (counter_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param (WIDTH=8, MAX_VAL=9, STEP_W=3): directed scenarios
// plus randomized traffic against an integer reference model.
module tb_updown_counter_param;

  localparam int WIDTH   = 8;
  localparam int MAX_VAL = 9;
  localparam int STEP_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b0;
  logic              direction = 1'b0;
  logic [STEP_W-1:0] step = '0;
  logic              load = 1'b0;
  logic [WIDTH-1:0]  load_value = '0;
  logic              clr_flag = 1'b0;
  logic [WIDTH-1:0]  counter_out;
  logic              wrap;
  logic              ovf_sticky;
  logic              at_max;
  logic              at_zero;

  int checks = 0;
  int failures = 0;

  int m_cnt = 0;
  int m_wrap = 0;
  int m_ovf = 0;

  updown_counter_param #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .direction(direction), .step(step),
    .load(load), .load_value(load_value), .clr_flag(clr_flag),
    .counter_out(counter_out), .wrap(wrap), .ovf_sticky(ovf_sticky),
    .at_max(at_max), .at_zero(at_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour from the counting rules, in plain integer arithmetic.
  task automatic model_edge();
    int nv;
    int w;
    w = 0;
    nv = m_cnt;
    if (load) begin
      nv = (int'(load_value) > MAX_VAL) ? MAX_VAL : int'(load_value);
    end else if (enable && step != 0) begin
      if (direction) begin
        nv = m_cnt + int'(step);
        if (nv > MAX_VAL) begin
          w = 1;
`ifdef UPDOWN_COUNTER_SAT_EN
          nv = MAX_VAL;
`else
          nv = nv % (MAX_VAL + 1);
`endif
        end
      end else begin
        nv = m_cnt - int'(step);
        if (nv < 0) begin
          w = 1;
`ifdef UPDOWN_COUNTER_SAT_EN
          nv = 0;
`else
          nv = nv + MAX_VAL + 1;
`endif
        end
      end
    end
    m_cnt = nv;
    m_wrap = w;
    if (w == 1) m_ovf = 1;
    else if (clr_flag) m_ovf = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".cnt"}, int'(counter_out), m_cnt);
    check({tag, ".wrap"}, int'(wrap), m_wrap);
    check({tag, ".ovf"}, int'(ovf_sticky), m_ovf);
    check({tag, ".at_max"}, int'(at_max), (m_cnt == MAX_VAL) ? 1 : 0);
    check({tag, ".at_zero"}, int'(at_zero), (m_cnt == 0) ? 1 : 0);
  endtask

  task automatic do_edge(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // Reset pulse between edges; outputs must clear without a clock.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    m_cnt = 0;
    m_wrap = 0;
    m_ovf = 0;
    check_outputs(tag);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drive(input logic en, input logic dir, input int st, input logic ld,
                       input int lv, input logic clr);
    enable = en;
    direction = dir;
    step = STEP_W'(st);
    load = ld;
    load_value = WIDTH'(lv);
    clr_flag = clr;
  endtask

  int up_exp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_held");
    rst_n = 1'b1;

    // Count up by 1 across the terminal count.
    drive(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      do_edge("up1");
`ifndef UPDOWN_COUNTER_SAT_EN
      check("up1.table", int'(counter_out), up_exp[i]);
      check("up1.wrap_tbl", int'(wrap), (i == 9) ? 1 : 0);
`endif
    end

    // Load 7 while clearing the flag, then count down by 3.
    drive(0, 0, 3, 1, 7, 1);
    do_edge("load7");
    drive(1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_edge("down3");
`ifndef UPDOWN_COUNTER_SAT_EN
    check("down3.final", int'(counter_out), 5);
    check("down3.ovf", int'(ovf_sticky), 1);
`endif

    // Oversized load clamps; load beats enable.
    drive(1, 1, 2, 1, 200, 0);
    do_edge("load200");
    check("load200.at_max", int'(at_max), 1);

    drive(0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) do_edge("hold_en");
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) do_edge("hold_step");

    // clr_flag coincident with a boundary event, then alone.
    drive(1, 1, 1, 0, 0, 1);
    do_edge("clr_vs_wrap");
    drive(0, 1, 1, 0, 0, 1);
    do_edge("clr_alone");

    // Reset mid-count, then resume from 0.
    drive(1, 1, 2, 0, 0, 0);
    do_edge("pre_rst");
    do_edge("pre_rst");
    reset_pulse("rst_mid");
    do_edge("post_rst");

`ifdef UPDOWN_COUNTER_SAT_EN
    drive(0, 1, 3, 1, 8, 0);
    do_edge("sat_load8");
    drive(1, 1, 3, 0, 0, 0);
    do_edge("sat_up");
    check("sat_up.val", int'(counter_out), 9);
    do_edge("sat_hold");
    check("sat_hold.wrap", int'(wrap), 1);
    drive(0, 0, 2, 1, 1, 0);
    do_edge("sat_load1");
    drive(1, 0, 2, 0, 0, 0);
    do_edge("sat_down");
    check("sat_down.val", int'(counter_out), 0);
`endif

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 7),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 255), ($urandom_range(0, 7) == 0));
      do_edge("rand");
      if ($urandom_range(0, 49) == 0) reset_pulse("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
